// File: rtl/aes_key_sched_pkg.sv
// Shared types, index constants and GF(2^8) helpers for the AES-128 key schedule.
package aes_key_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  localparam logic [3:0] AES_KSCHED_FIRST = 4'd0;
  localparam logic [3:0] AES_KSCHED_LAST  = 4'd10;

  // Multiply by x in GF(2^8) with the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] times2(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = times2(aa);
    end
    return p;
  endfunction

  // Rcon(n) for n = 1..10, i.e. x^(n-1) in byte 0.
  function automatic logic [7:0] rcon(input logic [3:0] n);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 2; i <= 10; i++) begin
      if (4'(i) <= n) r = times2(r);
    end
    return r;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[7:0], w[31:8]};
  endfunction

endpackage

// File: rtl/aes_forward_sbox.sv
// Forward AES S-box: multiplicative inverse (x^254) followed by the affine map.
module aes_forward_sbox
  import aes_key_sched_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;

  always_comb begin
    x2   = gf_mul(in_byte, in_byte);
    x3   = gf_mul(x2, in_byte);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    // 240 + 12 + 2 = 254; zero maps to zero as AES requires
    inv  = gf_mul(gf_mul(x240, x12), x2);
    out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_sub_word.sv
// SubWord: forward S-box applied to each byte of a 32-bit word.
module aes_sub_word (
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_forward_sbox u_sbox (
      .in_byte  (word_in[8*b +: 8]),
      .out_byte (word_out[8*b +: 8])
    );
  end

endmodule

// File: rtl/aes_key_sched.sv
// AES-128 round-key sequencer, one key per accepted beat, forward or backward.
// Backward stepping is built only when AES_KSCHED_BACKWARD_EN is defined.
module aes_key_sched
  import aes_key_sched_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         dir,
  input  logic [127:0] key_in,
  output logic [127:0] rk,
  output logic [3:0]   rk_idx,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy,
  output logic         done
);

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   idx_q, idx_d;
  logic         dir_q, dir_d;
  logic         done_q, done_d;
  logic         dir_sel;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  sw_in, sw_out;
  logic [127:0] key_next;

  assign w0 = key_q[31:0];
  assign w1 = key_q[63:32];
  assign w2 = key_q[95:64];
  assign w3 = key_q[127:96];

  aes_sub_word u_sub_word (
    .word_in  (sw_in),
    .word_out (sw_out)
  );

  // Forward step from key i uses Rcon(i+1) on the old w3.
  logic [31:0] fw_t, fw0, fw1, fw2, fw3;
  always_comb begin
    fw_t = sw_out ^ {24'h0, rcon(idx_q + 4'd1)};
    fw0  = w0 ^ fw_t;
    fw1  = w1 ^ fw0;
    fw2  = w2 ^ fw1;
    fw3  = w3 ^ fw2;
  end

`ifdef AES_KSCHED_BACKWARD_EN
  // Backward step recovers w3' first, then feeds it through the shared SubWord.
  logic [31:0] bw3;
  assign dir_sel = dir;
  assign bw3     = w3 ^ w2;
  assign sw_in   = dir_q ? rot_word(bw3) : rot_word(w3);
  assign key_next = dir_q
    ? {bw3, w2 ^ w1, w1 ^ w0, w0 ^ sw_out ^ {24'h0, rcon(idx_q)}}
    : {fw3, fw2, fw1, fw0};
`else
  logic dir_unused;
  assign dir_unused = dir;
  assign dir_sel    = 1'b0;
  assign sw_in      = rot_word(w3);
  assign key_next   = {fw3, fw2, fw1, fw0};
`endif

  // Handshake: a beat transfers on a rising edge where rk_valid && rk_ready;
  // while rk_ready is low the beat (rk, rk_idx) is held unchanged.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key_in;
          dir_d   = dir_sel;
          idx_d   = dir_sel ? AES_KSCHED_LAST : AES_KSCHED_FIRST;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (idx_q == (dir_q ? AES_KSCHED_FIRST : AES_KSCHED_LAST)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_d = key_next;
            idx_d = dir_q ? idx_q - 4'd1 : idx_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  assign rk_valid = (state_q == EMIT);
  assign busy     = rk_valid;
  assign rk       = rk_valid ? key_q : '0;
  assign rk_idx   = rk_valid ? idx_q : '0;
  assign done     = done_q;

endmodule

// File: doc/aes_key_sched.md
AES_KEY_SCHED -- requirements
Module: aes_key_sched

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: begins a schedule run; sampled only in IDLE.
REQ-004 SHALL have port dir, input, 1 bit: 0 runs forward from the cipher key (round 0 to round 10); 1 runs backward from the round-10 key (round 10 to round 0).
REQ-005 SHALL have port key_in, input, 128 bits: starting key; byte 0 in [7:0]; word wN = key_in[32N+31:32N].
REQ-006 SHALL have port rk, output, 128 bits: current round key, same packing as key_in.
REQ-007 SHALL have port rk_idx, output, 4 bits: round number of rk, 0..10.
REQ-008 SHALL have port rk_valid, output, 1 bit; and port rk_ready, input, 1 bit: beat handshake.
REQ-009 SHALL have port busy, output, 1 bit; and port done, output, 1 bit.

Function
REQ-010 SHALL implement states IDLE and EMIT only.
REQ-011 In IDLE with start=1, SHALL load key_in and set idx to 10 if dir=1, otherwise 0, then enter EMIT on the next edge, so rk_valid is high one cycle after start.
REQ-012 In EMIT, SHALL drive rk_valid=1, rk = key register and rk_idx = idx; rk and rk_idx SHALL be 0 whenever rk_valid=0.
REQ-013 A beat is accepted only when rk_valid and rk_ready are both 1; rk and rk_idx SHALL stay stable while rk_ready=0.
REQ-014 On an accepted non-final beat, SHALL update the key register and idx (+1 forward, -1 backward) on the same edge, giving one key per cycle with rk_ready held high.
REQ-015 Forward step from key i: t = SubWord(RotWord(w3)) ^ Rcon(i+1); w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
REQ-016 Backward step from key i: w3' = w3^w2; w2' = w2^w1; w1' = w1^w0; w0' = w0 ^ SubWord(RotWord(w3')) ^ Rcon(i).
REQ-017 RotWord(w) SHALL equal {w[7:0], w[31:8]}; SubWord SHALL apply the forward AES S-box to each byte.
REQ-018 Rcon(1..10) SHALL be 01,02,04,08,10,20,40,80,1b,36 in byte 0, with zeros in the upper bytes.
REQ-019 The final beat is idx=10 (forward) or idx=0 (backward). After it is accepted, SHALL return to IDLE and pulse done=1 for exactly the following cycle.
REQ-020 busy SHALL be 1 exactly while in EMIT.
REQ-021 start while busy=1 SHALL be ignored; key_in and dir are sampled only on the start cycle.
REQ-022 Start asserted in the done cycle SHALL be accepted, because the state is already IDLE.

Reset
REQ-023 rst=1 SHALL force IDLE, clear the key register and idx, and drive rk=0, rk_idx=0, rk_valid=0, busy=0, done=0 on the next edge, including mid-run.
REQ-024 rst SHALL take priority over start and over the handshake in the same cycle.

Configuration
REQ-025 Macro AES_KSCHED_BACKWARD_EN defined: dir and the REQ-016 datapath are supported.
REQ-026 Macro AES_KSCHED_BACKWARD_EN undefined: the dir port SHALL remain present but be ignored, the run is always forward, and the backward datapath is not built.

Structure
REQ-027 The shared defines include SHALL hold the state encodings, the AES_KSCHED_* index constants (first 0, last 10) and the times2 xtime function used to generate Rcon.
REQ-028 SHALL instantiate one sub-module, aes_sub_word: four aes_forward_sbox instances on a 32-bit word, shared by both directions.

Verification
REQ-029 Forward FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c (byte 0 = 2b), rk_ready=1 -> 11 consecutive beats; rk_idx=1 gives a0fafe1788542cb123a339392a6c7605; rk_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6; done one cycle later.
REQ-030 Backward with key_in = d014f9a8c9ee2589e13f0cc8b6630ca6 -> rk_idx counts 10..0; the idx=0 beat equals 2b7e151628aed2a6abf7158809cf4f3c.
REQ-031 rk_ready toggled randomly during a forward run -> rk/rk_idx stable while stalled; identical 11-key sequence.
REQ-032 rst asserted at the idx=5 beat -> next cycle all outputs 0, state IDLE; a new start then produces rk_idx=0 again.
REQ-033 start pulsed mid-run with a different key_in -> sequence unaffected; start in the done cycle -> new run begins, first rk_valid the next cycle.
REQ-034 Build without AES_KSCHED_BACKWARD_EN, dir=1 -> forward sequence identical to REQ-029.
